block_sbox_seq: RTL and testbench

- Multi-byte, handshaked front end for the CSA block-cipher S-box. Substitutes every byte of a LANES-byte word.
- Uses SBOX_INST parallel lookups per cycle, so the team can trade area against throughput. With SBOX_INST = LANES it is fully parallel.
- Sits between the block-cipher round datapath and the key-schedule/round logic.
- Replaces ad-hoc instantiation of single-byte S-boxes.

---
 rtl/csa_pkg.sv | 43 ++++
 rtl/block_sbox.sv | 19 +
 rtl/block_sbox_seq.sv | 142 ++++++++++++++
 tb/tb_block_sbox_seq.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : csa_pkg                                                      |
// | Purpose   : Shared types, the CSA block-cipher S-box table and its       |
// |             lookup function, plus the sequencer state encoding.          |
// | Contents  : byte_t, seq_state_t, CSA_SBOX[256], csa_sbox()               |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
package csa_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_t;

  localparam byte_t CSA_SBOX [256] = '{
    8'h3a, 8'hea, 8'h68, 8'hfe, 8'h33, 8'he9, 8'h88, 8'h1a, 8'h83, 8'hcf, 8'he1, 8'h7f, 8'hba, 8'he2, 8'h38, 8'h12,
    8'he8, 8'h27, 8'h61, 8'h95, 8'h0c, 8'h36, 8'he5, 8'h70, 8'ha2, 8'h06, 8'h82, 8'h7c, 8'h17, 8'ha3, 8'h26, 8'h49,
    8'hbe, 8'h7a, 8'h6d, 8'h47, 8'hc1, 8'h51, 8'h8f, 8'hf3, 8'hcc, 8'h5b, 8'h67, 8'hbd, 8'hcd, 8'h18, 8'h08, 8'hc9,
    8'hff, 8'h69, 8'hef, 8'h03, 8'h4e, 8'h48, 8'h4a, 8'h84, 8'h3f, 8'hb4, 8'h10, 8'h04, 8'hdc, 8'hf5, 8'h5c, 8'hc6,
    8'h16, 8'hab, 8'hac, 8'h4c, 8'hf1, 8'h6a, 8'h2f, 8'h3c, 8'h3b, 8'hd4, 8'hd5, 8'h94, 8'hd0, 8'hc4, 8'h63, 8'h62,
    8'h71, 8'ha1, 8'hf9, 8'h4f, 8'h2e, 8'haa, 8'hc5, 8'h56, 8'he3, 8'h39, 8'h93, 8'hce, 8'h65, 8'h64, 8'he4, 8'h58,
    8'h6c, 8'h19, 8'h42, 8'h79, 8'hdd, 8'hee, 8'h96, 8'hf6, 8'h8a, 8'hec, 8'h1e, 8'h85, 8'h53, 8'h45, 8'hde, 8'hbb,
    8'h7e, 8'h0a, 8'h9a, 8'h13, 8'h2a, 8'h9d, 8'hc2, 8'h5e, 8'h5a, 8'h1f, 8'h32, 8'h35, 8'h9c, 8'ha8, 8'h73, 8'h30,
    8'h29, 8'h3d, 8'he7, 8'h92, 8'h87, 8'h1b, 8'h2b, 8'h4b, 8'ha5, 8'h57, 8'h97, 8'h40, 8'h15, 8'he6, 8'hbc, 8'h0e,
    8'heb, 8'hc3, 8'h34, 8'h2d, 8'hb8, 8'h44, 8'h25, 8'ha4, 8'h1c, 8'hc7, 8'h23, 8'hed, 8'h90, 8'h6e, 8'h50, 8'h00,
    8'h99, 8'h9e, 8'h4d, 8'hd9, 8'hda, 8'h8d, 8'h6f, 8'h5f, 8'h3e, 8'hd7, 8'h21, 8'h74, 8'h86, 8'hdf, 8'h6b, 8'h05,
    8'h8e, 8'h5d, 8'h37, 8'h11, 8'hd2, 8'h28, 8'h75, 8'hd6, 8'ha7, 8'h77, 8'h24, 8'hbf, 8'hf0, 8'hb0, 8'h02, 8'hb7,
    8'hf8, 8'hfc, 8'h81, 8'h09, 8'hb1, 8'h01, 8'h76, 8'h91, 8'h7d, 8'h0f, 8'hc8, 8'ha0, 8'hf2, 8'hcb, 8'h78, 8'h60,
    8'hd1, 8'hf7, 8'he0, 8'hb5, 8'h98, 8'h22, 8'hb3, 8'h20, 8'h1d, 8'ha6, 8'hdb, 8'h7b, 8'h59, 8'h9f, 8'hae, 8'h31,
    8'hfb, 8'hd3, 8'hb6, 8'hca, 8'h43, 8'h72, 8'h07, 8'hf4, 8'hd8, 8'h41, 8'h14, 8'h55, 8'h0d, 8'h54, 8'h8b, 8'hb9,
    8'had, 8'h46, 8'h0b, 8'haf, 8'h80, 8'h52, 8'h2c, 8'hfa, 8'h8c, 8'h89, 8'h66, 8'hfd, 8'hb2, 8'ha9, 8'h9b, 8'hc0
  };

  function automatic byte_t csa_sbox(input byte_t x);
    return CSA_SBOX[x];
  endfunction

endpackage
`default_nettype wire

// File: rtl/block_sbox.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : block_sbox                                                   |
// | Purpose   : Combinational single-byte CSA block-cipher S-box.            |
// | Ports     : din  - input byte                                            |
// |             dout - substituted byte                                      |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module block_sbox
  import csa_pkg::*;
(
  input  byte_t din,
  output byte_t dout
);

  assign dout = csa_sbox(din);

endmodule
`default_nettype wire

// File: rtl/block_sbox_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : block_sbox_seq                                               |
// | Purpose   : Handshaked multi-byte CSA S-box front end. Substitutes all   |
// |             LANES bytes of a word using SBOX_INST lookups per cycle,     |
// |             taking BEATS = LANES/SBOX_INST cycles per word.              |
// | Ports     : clk, rst_n (async, active-low), clr (sync abort)             |
// |             in_valid/in_ready/in_data   - word input handshake           |
// |             out_valid/out_ready/out_data - result output handshake       |
// |             busy - high while a word is in RUN or DONE                   |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module block_sbox_seq
  import csa_pkg::*;
#(
  parameter int LANES     = 8,
  parameter int SBOX_INST = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               busy
);

  localparam int               BEATS     = LANES / SBOX_INST;
  localparam int               CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if ((SBOX_INST < 1) || (SBOX_INST > LANES) || ((LANES % SBOX_INST) != 0)) begin : g_bad_params
    $error("block_sbox_seq: SBOX_INST must lie in 1..LANES and divide LANES");
  end

  seq_state_t         state_q;
  seq_state_t         state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [8*LANES-1:0] hold_q;
  logic [8*LANES-1:0] data_q;
  logic               accept;

  byte_t sb_in  [SBOX_INST];
  byte_t sb_out [SBOX_INST];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = SEQ_RUN;
      end
      SEQ_RUN: begin
        if (cnt_q == LAST_BEAT) state_d = SEQ_DONE;
      end
      SEQ_DONE: begin
        // Releasing the result frees the holding register in the same
        // cycle, so a waiting word can go straight back into RUN.
        in_ready = out_ready;
        if (out_ready) state_d = in_valid ? SEQ_RUN : SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
    // Abort wins over everything, including a pending accept.
    if (clr) begin
      state_d  = SEQ_IDLE;
      in_ready = 1'b0;
    end
  end

  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == SEQ_DONE);
  assign busy      = (state_q != SEQ_IDLE);
  assign out_data  = data_q;

  // ---------------------------------------------------------- beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || accept) begin
      cnt_q <= '0;
    end else if (state_q == SEQ_RUN) begin
      cnt_q <= (cnt_q == LAST_BEAT) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // ------------------------------------------------------ holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (accept) begin
      hold_q <= in_data;
    end
  end

  // ------------------------------------------------------------ lane mux
  // S-box instance i serves lane b*SBOX_INST+i during beat b. The beat
  // comparison is against constants, so the mux never indexes out of range.
  always_comb begin
    for (int i = 0; i < SBOX_INST; i++) begin
      sb_in[i] = hold_q[8*i +: 8];
      for (int b = 0; b < BEATS; b++) begin
        if (cnt_q == CNT_W'(b)) sb_in[i] = hold_q[8*(b*SBOX_INST + i) +: 8];
      end
    end
  end

  for (genvar g = 0; g < SBOX_INST; g++) begin : g_sbox
    block_sbox u_sbox (
      .din  (sb_in[g]),
      .dout (sb_out[g])
    );
  end

  // ------------------------------------------------------ result register
  // Only the lanes belonging to the current beat are written; lanes not yet
  // reached keep stale data, hidden behind out_valid = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (state_q == SEQ_RUN) begin
      for (int k = 0; k < LANES; k++) begin
        if (cnt_q == CNT_W'(k / SBOX_INST)) data_q[8*k +: 8] <= sb_out[k % SBOX_INST];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_block_sbox_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_block_sbox_seq                                            |
// | Purpose   : Self-checking bench for block_sbox_seq. Three instances:     |
// |             index 0 -> SBOX_INST=2, index 1 -> SBOX_INST=8,              |
// |             index 2 -> SBOX_INST=1 (all LANES=8).                        |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_block_sbox_seq;

  localparam int LANES = 8;
  localparam int W     = 8 * LANES;

  localparam logic [7:0] REF_SBOX [256] = '{
    8'h3a, 8'hea, 8'h68, 8'hfe, 8'h33, 8'he9, 8'h88, 8'h1a, 8'h83, 8'hcf, 8'he1, 8'h7f, 8'hba, 8'he2, 8'h38, 8'h12,
    8'he8, 8'h27, 8'h61, 8'h95, 8'h0c, 8'h36, 8'he5, 8'h70, 8'ha2, 8'h06, 8'h82, 8'h7c, 8'h17, 8'ha3, 8'h26, 8'h49,
    8'hbe, 8'h7a, 8'h6d, 8'h47, 8'hc1, 8'h51, 8'h8f, 8'hf3, 8'hcc, 8'h5b, 8'h67, 8'hbd, 8'hcd, 8'h18, 8'h08, 8'hc9,
    8'hff, 8'h69, 8'hef, 8'h03, 8'h4e, 8'h48, 8'h4a, 8'h84, 8'h3f, 8'hb4, 8'h10, 8'h04, 8'hdc, 8'hf5, 8'h5c, 8'hc6,
    8'h16, 8'hab, 8'hac, 8'h4c, 8'hf1, 8'h6a, 8'h2f, 8'h3c, 8'h3b, 8'hd4, 8'hd5, 8'h94, 8'hd0, 8'hc4, 8'h63, 8'h62,
    8'h71, 8'ha1, 8'hf9, 8'h4f, 8'h2e, 8'haa, 8'hc5, 8'h56, 8'he3, 8'h39, 8'h93, 8'hce, 8'h65, 8'h64, 8'he4, 8'h58,
    8'h6c, 8'h19, 8'h42, 8'h79, 8'hdd, 8'hee, 8'h96, 8'hf6, 8'h8a, 8'hec, 8'h1e, 8'h85, 8'h53, 8'h45, 8'hde, 8'hbb,
    8'h7e, 8'h0a, 8'h9a, 8'h13, 8'h2a, 8'h9d, 8'hc2, 8'h5e, 8'h5a, 8'h1f, 8'h32, 8'h35, 8'h9c, 8'ha8, 8'h73, 8'h30,
    8'h29, 8'h3d, 8'he7, 8'h92, 8'h87, 8'h1b, 8'h2b, 8'h4b, 8'ha5, 8'h57, 8'h97, 8'h40, 8'h15, 8'he6, 8'hbc, 8'h0e,
    8'heb, 8'hc3, 8'h34, 8'h2d, 8'hb8, 8'h44, 8'h25, 8'ha4, 8'h1c, 8'hc7, 8'h23, 8'hed, 8'h90, 8'h6e, 8'h50, 8'h00,
    8'h99, 8'h9e, 8'h4d, 8'hd9, 8'hda, 8'h8d, 8'h6f, 8'h5f, 8'h3e, 8'hd7, 8'h21, 8'h74, 8'h86, 8'hdf, 8'h6b, 8'h05,
    8'h8e, 8'h5d, 8'h37, 8'h11, 8'hd2, 8'h28, 8'h75, 8'hd6, 8'ha7, 8'h77, 8'h24, 8'hbf, 8'hf0, 8'hb0, 8'h02, 8'hb7,
    8'hf8, 8'hfc, 8'h81, 8'h09, 8'hb1, 8'h01, 8'h76, 8'h91, 8'h7d, 8'h0f, 8'hc8, 8'ha0, 8'hf2, 8'hcb, 8'h78, 8'h60,
    8'hd1, 8'hf7, 8'he0, 8'hb5, 8'h98, 8'h22, 8'hb3, 8'h20, 8'h1d, 8'ha6, 8'hdb, 8'h7b, 8'h59, 8'h9f, 8'hae, 8'h31,
    8'hfb, 8'hd3, 8'hb6, 8'hca, 8'h43, 8'h72, 8'h07, 8'hf4, 8'hd8, 8'h41, 8'h14, 8'h55, 8'h0d, 8'h54, 8'h8b, 8'hb9,
    8'had, 8'h46, 8'h0b, 8'haf, 8'h80, 8'h52, 8'h2c, 8'hfa, 8'h8c, 8'h89, 8'h66, 8'hfd, 8'hb2, 8'ha9, 8'h9b, 8'hc0
  };

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] dout;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   clr;
  logic [2:0]   in_valid;
  logic [2:0]   out_ready;
  wire  [2:0]   in_ready;
  wire  [2:0]   out_valid;
  wire  [2:0]   busy;
  logic [W-1:0] in_data  [3];
  logic [W-1:0] out_data [3];

  int checks   = 0;
  int failures = 0;
  int nout [3] = '{0, 0, 0};
  bit done6;

  logic [W-1:0] sb0 [$];
  logic [W-1:0] sb1 [$];
  logic [W-1:0] sb2 [$];

  always #5 clk = ~clk;

  block_sbox_seq #(.LANES(LANES), .SBOX_INST(2)) u_dut_p2 (
    .clk(clk), .rst_n(rst_n), .clr(clr[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .busy(busy[0])
  );

  block_sbox_seq #(.LANES(LANES), .SBOX_INST(8)) u_dut_p8 (
    .clk(clk), .rst_n(rst_n), .clr(clr[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .busy(busy[1])
  );

  block_sbox_seq #(.LANES(LANES), .SBOX_INST(1)) u_dut_p1 (
    .clk(clk), .rst_n(rst_n), .clr(clr[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .busy(busy[2])
  );

  function automatic logic [W-1:0] model(input logic [W-1:0] x);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) r[8*k +: 8] = REF_SBOX[x[8*k +: 8]];
    return r;
  endfunction

  function automatic void sb_push(input int d, input logic [W-1:0] v);
    case (d)
      0:       sb0.push_back(v);
      1:       sb1.push_back(v);
      default: sb2.push_back(v);
    endcase
  endfunction

  function automatic int sb_size(input int d);
    case (d)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  function automatic logic [W-1:0] sb_pop(input int d);
    case (d)
      0:       return sb0.pop_front();
      1:       return sb1.pop_front();
      default: return sb2.pop_front();
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitor: a result is taken at the next rising edge whenever
  // out_valid and out_ready are both high at the falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int d = 0; d < 3; d++) begin
        if (out_valid[d] && out_ready[d] && !clr[d]) begin
          nout[d]++;
          if (sb_size(d) == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output dut%0d: got %h expected no word", d, out_data[d]);
          end else begin
            check($sformatf("out_data dut%0d", d), out_data[d], sb_pop(d));
          end
        end
      end
    end
  end

  // All tasks start and return just after a rising edge.
  task automatic send(input int d, input logic [W-1:0] data, input logic [W-1:0] exp, input bit track);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    in_data[d]  = data;
    in_valid[d] = 1'b1;
    while (!ok && n < 60) begin
      @(negedge clk);
      if (in_ready[d]) begin
        ok = 1'b1;
        if (track) sb_push(d, exp);
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid[d] = 1'b0;
    check($sformatf("send_accepted dut%0d", d), W'(ok), W'(1));
  endtask

  task automatic expect_latency(input int d, input int beats);
    for (int k = 0; k < beats; k++) begin
      @(negedge clk);
      check($sformatf("run_out_valid dut%0d beat%0d", d, k), W'(out_valid[d]), W'(0));
      check($sformatf("run_in_ready dut%0d beat%0d", d, k), W'(in_ready[d]), W'(0));
    end
    @(negedge clk);
    check($sformatf("done_out_valid dut%0d", d), W'(out_valid[d]), W'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int d, input int budget);
    int n;
    n = 0;
    while (sb_size(d) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check($sformatf("drained dut%0d", d), W'(sb_size(d)), W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    logic [W-1:0] x;
    int acc;
    bit seen;

    vecs[0] = '{din: 64'h0706050403020100, dout: 64'h1A88E933FE68EA3A};
    vecs[1] = '{din: 64'hFF9F550000000000, dout: 64'hC000AA3A3A3A3A3A};
    vecs[2] = '{din: 64'h0000000000000000, dout: 64'h3A3A3A3A3A3A3A3A};
    vecs[3] = '{din: 64'hFFFFFFFFFFFFFFFF, dout: 64'hC0C0C0C0C0C0C0C0};
    x = {$urandom, $urandom};
    vecs[4] = '{din: x, dout: model(x)};
    x = {$urandom, $urandom};
    vecs[5] = '{din: x, dout: model(x)};

    rst_n     = 1'b0;
    clr       = '0;
    in_valid  = '0;
    out_ready = '0;
    for (int d = 0; d < 3; d++) in_data[d] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_in_ready dut%0d", d), W'(in_ready[d]), W'(1));
      check($sformatf("reset_out_valid dut%0d", d), W'(out_valid[d]), W'(0));
      check($sformatf("reset_busy dut%0d", d), W'(busy[d]), W'(0));
      check($sformatf("reset_out_data dut%0d", d), out_data[d], '0);
    end
    @(posedge clk);
    #1;

    // Table-driven words with latency profile, SBOX_INST=2.
    out_ready[0] = 1'b1;
    for (int v = 0; v < 6; v++) begin
      send(0, vecs[v].din, vecs[v].dout, 1'b1);
      expect_latency(0, 4);
    end

    // Back-pressure, then a new word accepted in the release cycle.
    out_ready[0] = 1'b0;
    send(0, 64'h0706050403020100, 64'h1A88E933FE68EA3A, 1'b1);
    expect_latency(0, 4);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_out_valid", W'(out_valid[0]), W'(1));
      check("stall_in_ready", W'(in_ready[0]), W'(0));
      check("stall_out_data", out_data[0], 64'h1A88E933FE68EA3A);
      @(posedge clk);
      #1;
    end
    out_ready[0] = 1'b1;
    send(0, 64'hFF9F550000000000, 64'hC000AA3A3A3A3A3A, 1'b1);
    expect_latency(0, 4);

    // Fully parallel instance: one-cycle latency, one word per two cycles.
    out_ready[1] = 1'b1;
    send(1, 64'hFFFFFFFFFFFFFFFF, 64'hC0C0C0C0C0C0C0C0, 1'b1);
    expect_latency(1, 1);
    acc = 0;
    in_data[1]  = {$urandom, $urandom};
    in_valid[1] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      seen = 1'b0;
      @(negedge clk);
      if (in_ready[1]) begin
        sb_push(1, model(in_data[1]));
        acc++;
        seen = 1'b1;
      end
      @(posedge clk);
      #1;
      if (seen) in_data[1] = {$urandom, $urandom};
    end
    in_valid[1] = 1'b0;
    check("stream_accepts", W'(acc), W'(10));
    drain(1, 50);

    // clr in the middle of RUN drops the word.
    send(0, 64'h1122334455667788, '0, 1'b0);
    @(posedge clk);
    #1;
    clr[0] = 1'b1;
    @(negedge clk);
    check("clr_in_ready", W'(in_ready[0]), W'(0));
    @(posedge clk);
    #1;
    clr[0] = 1'b0;
    @(negedge clk);
    check("clr_busy", W'(busy[0]), W'(0));
    check("clr_idle_in_ready", W'(in_ready[0]), W'(1));
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1'b1;
    end
    check("clr_no_output", W'(seen), W'(0));
    @(posedge clk);
    #1;
    // clr together with in_valid in IDLE: word refused.
    in_data[0]  = 64'hDEADBEEFDEADBEEF;
    in_valid[0] = 1'b1;
    clr[0]      = 1'b1;
    @(negedge clk);
    check("clr_valid_in_ready", W'(in_ready[0]), W'(0));
    @(posedge clk);
    #1;
    clr[0]      = 1'b0;
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("clr_valid_busy", W'(busy[0]), W'(0));
    @(posedge clk);
    #1;
    send(0, 64'h0000000000000000, 64'h3A3A3A3A3A3A3A3A, 1'b1);
    expect_latency(0, 4);

    // Asynchronous reset while holding a result in DONE.
    out_ready[0] = 1'b0;
    send(0, 64'h0706050403020100, 64'h1A88E933FE68EA3A, 1'b1);
    expect_latency(0, 4);
    @(negedge clk);
    check("pre_reset_busy", W'(busy[0]), W'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_out_valid", W'(out_valid[0]), W'(0));
    check("areset_busy", W'(busy[0]), W'(0));
    check("areset_out_data", out_data[0], '0);
    check("areset_in_ready", W'(in_ready[0]), W'(1));
    sb0.delete();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;

    // Exhaustive byte sweep on the single-lookup instance with random gaps.
    done6 = 1'b0;
    nout[2] = 0;
    fork
      begin
        for (int w = 0; w < 32; w++) begin
          for (int k = 0; k < LANES; k++) x[8*k +: 8] = 8'(8*w + k);
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          send(2, x, model(x), 1'b1);
        end
        drain(2, 2000);
        done6 = 1'b1;
      end
      begin
        while (!done6) begin
          @(posedge clk);
          #1;
          out_ready[2] = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready[2] = 1'b1;
    check("sweep_word_count", W'(nout[2]), W'(32));
    check("final_queue_p2", W'(sb_size(0)), W'(0));

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
